fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the core's decode/execute stage.
//  - Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
//  - Buffers returned words with their PC in a small FIFO and presents them to decode over valid/ready.
//  - Supports pipeline redirects (jumps/branches) and stops fetching after the exit instruction.

---
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one word read in flight
// and queues returned words with their PCs for decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] EXIT_INST = 32'hc000_1073
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        exit
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_r, fetch_pc_n_s;
    logic          req_r, req_n_s;
    logic [31:0]   addr_r, addr_n_s;
    logic          halted_r, halted_n_s;
    logic          squash_r, squash_n_s;
    logic          exit_r, exit_n_s;
    logic          valid_r, valid_n_s;
    logic [31:0]   head_inst_r, head_inst_n_s;
    logic [31:0]   head_pc_r, head_pc_n_s;
    logic [AW:0]   count_r, count_n_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_n_s, rd_next_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_n_s;
    logic [31:0]   mem_inst_r [DEPTH];
    logic [31:0]   mem_pc_r   [DEPTH];

    logic ack_s, pop_s, exit_pop_s, redir_s, push_s;
    logic unused_redirect_lsb_s;

    assign unused_redirect_lsb_s = ^redirect_pc[1:0];

    // Acks only count while a request is up; a redirect loses to a same-cycle exit pop.
    assign ack_s      = req_r & imem_ack;
    assign pop_s      = valid_r & inst_ready;
    assign exit_pop_s = pop_s & (head_inst_r == EXIT_INST);
    assign redir_s    = redirect_valid & ~exit_r & ~exit_pop_s;
    assign push_s     = ack_s & ~squash_r & ~redir_s;
    assign rd_next_s  = rd_ptr_r + AW'(1);

    // Next-state decode for fetch PC, handshake, squash and FIFO bookkeeping.
    always_comb begin
        fetch_pc_n_s  = fetch_pc_r;
        halted_n_s    = halted_r;
        squash_n_s    = squash_r;
        count_n_s     = count_r;
        rd_ptr_n_s    = rd_ptr_r;
        wr_ptr_n_s    = wr_ptr_r;
        req_n_s       = 1'b0;
        addr_n_s      = addr_r;
        head_inst_n_s = head_inst_r;
        head_pc_n_s   = head_pc_r;
        valid_n_s     = valid_r;
        exit_n_s      = exit_r | exit_pop_s;

        if (redir_s) begin
            fetch_pc_n_s = {redirect_pc[31:2], 2'b00};
            halted_n_s   = 1'b0;
        end else if (push_s) begin
            fetch_pc_n_s = fetch_pc_r + 32'd4;
            halted_n_s   = halted_r | (imem_rdata == EXIT_INST);
        end else begin
            fetch_pc_n_s = fetch_pc_r;
            halted_n_s   = halted_r;
        end

        // A redirect while a read is in flight leaves the read held but marks its data stale.
        if (ack_s) begin
            squash_n_s = 1'b0;
        end else if (redir_s && req_r) begin
            squash_n_s = 1'b1;
        end else begin
            squash_n_s = squash_r;
        end

        if (redir_s) begin
            count_n_s  = '0;
            rd_ptr_n_s = '0;
            wr_ptr_n_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_n_s = count_r + (AW + 1)'(1);
                2'b01:   count_n_s = count_r - (AW + 1)'(1);
                default: count_n_s = count_r;
            endcase
            rd_ptr_n_s = pop_s  ? rd_next_s : rd_ptr_r;
            wr_ptr_n_s = push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
        end

        if (redir_s) begin
            head_inst_n_s = head_inst_r;
            head_pc_n_s   = head_pc_r;
        end else if (pop_s && (count_r > (AW + 1)'(1))) begin
            head_inst_n_s = mem_inst_r[rd_next_s];
            head_pc_n_s   = mem_pc_r[rd_next_s];
        end else if (push_s && ((count_r == '0) || pop_s)) begin
            head_inst_n_s = imem_rdata;
            head_pc_n_s   = fetch_pc_r;
        end else begin
            head_inst_n_s = head_inst_r;
            head_pc_n_s   = head_pc_r;
        end
        valid_n_s = (count_n_s != '0);

        // Reservation uses post-update occupancy so an ack cycle can chain the next read.
        if (req_r && !ack_s) begin
            req_n_s  = 1'b1;
            addr_n_s = addr_r;
        end else if (!halted_n_s && (count_n_s < DEPTH_C)) begin
            req_n_s  = 1'b1;
            addr_n_s = fetch_pc_n_s;
        end else begin
            req_n_s  = 1'b0;
            addr_n_s = addr_r;
        end
    end

    // State, output and FIFO storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r  <= RESET_PC;
            req_r       <= 1'b0;
            addr_r      <= RESET_PC;
            halted_r    <= 1'b0;
            squash_r    <= 1'b0;
            exit_r      <= 1'b0;
            valid_r     <= 1'b0;
            head_inst_r <= 32'd0;
            head_pc_r   <= 32'd0;
            count_r     <= '0;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst_r[i] <= 32'd0;
                mem_pc_r[i]   <= 32'd0;
            end
        end else begin
            fetch_pc_r  <= fetch_pc_n_s;
            req_r       <= req_n_s;
            addr_r      <= addr_n_s;
            halted_r    <= halted_n_s;
            squash_r    <= squash_n_s;
            exit_r      <= exit_n_s;
            valid_r     <= valid_n_s;
            head_inst_r <= head_inst_n_s;
            head_pc_r   <= head_pc_n_s;
            count_r     <= count_n_s;
            rd_ptr_r    <= rd_ptr_n_s;
            wr_ptr_r    <= wr_ptr_n_s;
            if (push_s) begin
                mem_inst_r[wr_ptr_r] <= imem_rdata;
                mem_pc_r[wr_ptr_r]   <= fetch_pc_r;
            end
        end
    end

    assign imem_req   = req_r;
    assign imem_addr  = addr_r;
    assign inst_valid = valid_r;
    assign inst       = head_inst_r;
    assign inst_pc    = head_pc_r;
    assign exit       = exit_r;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory responder, a per-cycle
// stream/handshake model, and hand-computed checks for each scenario.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] EXIT_W = 32'hc000_1073;
    localparam int          DEPTH  = 2;

    logic        clk, rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid, inst_valid, inst_ready, exit;
    logic [31:0] redirect_pc, inst, inst_pc;

    int          n_vec, n_bad, lat, wcnt;
    logic [31:0] exit_addr;

    // model state
    int          m_cnt;
    logic [31:0] m_exp_pc, m_req_pc, m_hold_addr, m_tgt;
    bit          m_busy, m_stale, m_halted, m_exit, m_exp_req;
    bit          t_pop, t_xpop, t_redir, t_ack, t_push;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH), .EXIT_INST(EXIT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .exit(exit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == exit_addr) ? EXIT_W : {a[15:0] ^ 16'h5a5a, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_req", imem_req, 32'd0);
        chk("rst_valid", inst_valid, 32'd0);
        chk("rst_exit", exit, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (!inst_valid && k < 30) begin
            tick();
            k++;
        end
        chk(nm, inst_valid, 32'd1);
    endtask

    task automatic wait_ack();
        int k;
        k = 0;
        while (!imem_ack && k < 20) begin
            tick();
            k++;
        end
        chk("ack_seen", imem_ack, 32'd1);
    endtask

    // Memory responder: acks a request after lat wait cycles, data from word_at.
    initial begin
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !imem_req) begin
                imem_ack = 1'b0;
                wcnt = 0;
            end else begin
                if (imem_ack) wcnt = 0;
                if (wcnt >= lat) begin
                    imem_ack = 1'b1;
                    imem_rdata = word_at(imem_addr);
                end else begin
                    imem_ack = 1'b0;
                    wcnt = wcnt + 1;
                end
            end
        end
    end

    // Per-cycle model: decode sees the in-order word stream from the current target,
    // requests follow the reservation rule and hold until acked.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                m_cnt = 0; m_exp_pc = 32'd0; m_req_pc = 32'd0; m_hold_addr = 32'd0;
                m_busy = 0; m_stale = 0; m_halted = 0; m_exit = 0; m_exp_req = 0;
                chk("m_rst_req", imem_req, 32'd0);
                chk("m_rst_valid", inst_valid, 32'd0);
                chk("m_rst_exit", exit, 32'd0);
            end else begin
                chk("m_exit", exit, m_exit);
                chk("m_req", imem_req, m_exp_req);
                chk("m_valid", inst_valid, m_cnt != 0);
                if (m_cnt != 0) begin
                    chk("m_inst_pc", inst_pc, m_exp_pc);
                    chk("m_inst", inst, word_at(m_exp_pc));
                end
                if (m_exp_req && !m_busy) m_hold_addr = m_req_pc;
                if (m_exp_req) chk("m_req_addr", imem_addr, m_hold_addr);

                t_pop   = (m_cnt != 0) && inst_ready;
                t_xpop  = t_pop && (word_at(m_exp_pc) == EXIT_W);
                t_redir = redirect_valid && !m_exit && !t_xpop;
                t_ack   = m_exp_req && imem_ack;
                t_push  = t_ack && !m_stale && !t_redir;
                if (t_push) begin
                    m_cnt++;
                    m_req_pc = m_hold_addr + 32'd4;
                    if (word_at(m_hold_addr) == EXIT_W) m_halted = 1;
                end
                if (t_pop) begin
                    m_cnt--;
                    m_exp_pc = m_exp_pc + 32'd4;
                end
                if (t_xpop) m_exit = 1;
                if (t_ack) m_stale = 0;
                if (t_redir) begin
                    m_tgt = {redirect_pc[31:2], 2'b00};
                    m_cnt = 0;
                    m_exp_pc = m_tgt;
                    m_req_pc = m_tgt;
                    m_halted = 0;
                    if (m_exp_req && !imem_ack) m_stale = 1;
                end
                chk("m_fifo_bound", m_cnt <= DEPTH, 32'd1);
                m_busy = m_exp_req && !imem_ack;
                m_exp_req = m_busy || (m_cnt < DEPTH && !m_halted);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        n_vec = 0; n_bad = 0; lat = 0; exit_addr = 32'hffff_ffff;
        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

        // 1: single-cycle memory, decode always ready
        inst_ready = 1'b1;
        do_reset();
        wait_valid("t1_fill");
        chk("t1_pc0", inst_pc, 32'h0);
        chk("t1_addr0", imem_addr, 32'h4);
        tick();
        chk("t1_pc1", inst_pc, 32'h4);
        chk("t1_addr1", imem_addr, 32'h8);
        tick();
        chk("t1_pc2", inst_pc, 32'h8);
        repeat (8) tick();

        // 2: decode stalls, FIFO fills and fetch stops
        inst_ready = 1'b0;
        repeat (10) tick();
        chk("t2_valid", inst_valid, 32'd1);
        chk("t2_req", imem_req, 32'd0);
        inst_ready = 1'b1;
        repeat (10) tick();

        // 3: slow memory, redirect in the second wait cycle
        lat = 3;
        k = 0;
        while (!(imem_req && !imem_ack && wcnt == 2) && k < 40) begin tick(); k++; end
        chk("t3_sync", wcnt, 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        wait_ack();
        tick();
        chk("t3_req", imem_req, 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        wait_valid("t3_fill");
        chk("t3_pc", inst_pc, 32'h100);

        // 3b: two redirects while squashed, last target wins
        k = 0;
        while (!(imem_req && !imem_ack && wcnt == 1) && k < 40) begin tick(); k++; end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        wait_ack();
        tick();
        chk("t3b_addr", imem_addr, 32'h400);
        wait_valid("t3b_fill");
        chk("t3b_pc", inst_pc, 32'h400);

        // 4: misaligned redirect target
        lat = 1;
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        chk("t4_empty", inst_valid, 32'd0);
        k = 0;
        while (!(imem_req && imem_addr == 32'h200) && k < 10) begin tick(); k++; end
        chk("t4_addr", imem_addr, 32'h200);
        wait_valid("t4_fill");
        chk("t4_pc", inst_pc, 32'h200);

        // 5: exit word at 0x10, redirect collides with its pop and later ones are ignored
        exit_addr = 32'h10; lat = 0; inst_ready = 1'b1;
        do_reset();
        k = 0;
        while (!(inst_valid && inst_pc == 32'h10) && k < 40) begin tick(); k++; end
        chk("t5_head", inst_pc, 32'h10);
        chk("t5_head_inst", inst, EXIT_W);
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        chk("t5_exit", exit, 32'd1);
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h600;
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        chk("t5_exit_hold", exit, 32'd1);
        chk("t5_no_req", imem_req, 32'd0);
        chk("t5_empty", inst_valid, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_exit", exit, 32'd0);
        tick();

        // 6: async reset mid-request with the FIFO holding a word
        exit_addr = 32'hffff_ffff; lat = 3; inst_ready = 1'b0;
        do_reset();
        k = 0;
        while (!(inst_valid && imem_req) && k < 40) begin tick(); k++; end
        chk("t6_busy", inst_valid && imem_req, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_req", imem_req, 32'd0);
        chk("t6_async_valid", inst_valid, 32'd0);
        chk("t6_async_exit", exit, 32'd0);
        tick();
        tick();
        lat = 0; inst_ready = 1'b1; rst_n = 1'b1;
        wait_valid("t6_fill");
        chk("t6_restart_pc", inst_pc, 32'h0);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
